// File: rtl/exc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : exc_arbiter
// Description : Writeback exception/ertn arbiter. Commits one event at a time,
//               redirects fetch, then holds flush for FLUSH_HOLD extra cycles.
//               Interrupt detection is built only with EXC_ARBITER_INT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_arbiter #(
    parameter int FLUSH_HOLD = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ex_adef,
    input  logic        wb_ex_ine,
    input  logic        wb_ex_sys,
    input  logic        wb_ex_brk,
    input  logic        wb_ex_ale,
    input  logic [31:0] wb_ale_addr,
    input  logic        wb_ertn,
    input  logic [12:0] csr_estat_is,
    input  logic [12:0] csr_ecfg_lie,
    input  logic        csr_crmd_ie,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        fetch_ready,
    output logic        ex_commit,
    output logic        ertn_commit,
    output logic [5:0]  ex_ecode,
    output logic [8:0]  ex_esubcode,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_badv,
    output logic        badv_we,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [3:0] c_HOLD       = 4'(FLUSH_HOLD);
    localparam logic [5:0] c_ECODE_INT  = 6'h00;
    localparam logic [5:0] c_ECODE_ADEF = 6'h08;
    localparam logic [5:0] c_ECODE_ALE  = 6'h09;
    localparam logic [5:0] c_ECODE_SYS  = 6'h0B;
    localparam logic [5:0] c_ECODE_BRK  = 6'h0C;
    localparam logic [5:0] c_ECODE_INE  = 6'h0D;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_REDIRECT = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_int_pend;
    logic        w_take_ex;
    logic        w_accept;
    logic [5:0]  w_ecode;
    logic [31:0] w_badv;
    logic        w_badv_we;
    logic        r_is_ertn;
    logic        r_badv_we;
    logic [5:0]  r_ecode;
    logic [31:0] r_pc;
    logic [31:0] r_badv;
    logic [31:0] r_redirect_pc;

`ifdef EXC_ARBITER_INT_EN
    logic r_int_pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_int_pend <= 1'b0;
        end else begin
            r_int_pend <= (|(csr_estat_is & csr_ecfg_lie)) & csr_crmd_ie;
        end
    end

    assign w_int_pend = r_int_pend;
`else
    logic w_unused_csr;

    assign w_unused_csr = ^{csr_estat_is, csr_ecfg_lie, csr_crmd_ie};
    assign w_int_pend   = 1'b0;
`endif

    assign w_take_ex = w_int_pend | wb_ex_adef | wb_ex_ine | wb_ex_sys |
                       wb_ex_brk | wb_ex_ale;
    assign w_accept  = (r_state == S_IDLE) && wb_valid && (w_take_ex || wb_ertn);

    // Priority encode; ertn falls through with don't-care ecode and no badv.
    always_comb begin
        w_ecode   = c_ECODE_INT;
        w_badv    = 32'h0;
        w_badv_we = 1'b0;
        if (w_int_pend) begin
            w_ecode = c_ECODE_INT;
        end else if (wb_ex_adef) begin
            w_ecode   = c_ECODE_ADEF;
            w_badv    = wb_pc;
            w_badv_we = 1'b1;
        end else if (wb_ex_ine) begin
            w_ecode = c_ECODE_INE;
        end else if (wb_ex_sys) begin
            w_ecode = c_ECODE_SYS;
        end else if (wb_ex_brk) begin
            w_ecode = c_ECODE_BRK;
        end else if (wb_ex_ale) begin
            w_ecode   = c_ECODE_ALE;
            w_badv    = wb_ale_addr;
            w_badv_we = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (fetch_ready) begin
                    if (c_HOLD != 4'd0) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = c_HOLD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Event fields are captured once at acceptance and held until the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_ertn     <= 1'b0;
            r_badv_we     <= 1'b0;
            r_ecode       <= 6'h0;
            r_pc          <= 32'h0;
            r_badv        <= 32'h0;
            r_redirect_pc <= 32'h0;
        end else if (w_accept) begin
            r_is_ertn     <= ~w_take_ex;
            r_badv_we     <= w_badv_we;
            r_ecode       <= w_ecode;
            r_pc          <= wb_pc;
            r_badv        <= w_badv;
            r_redirect_pc <= w_take_ex ? csr_eentry : csr_era;
        end
    end

    assign ex_commit      = (r_state == S_COMMIT) & ~r_is_ertn;
    assign ertn_commit    = (r_state == S_COMMIT) &  r_is_ertn;
    assign badv_we        = (r_state == S_COMMIT) &  r_badv_we;
    assign ex_ecode       = r_ecode;
    assign ex_esubcode    = 9'd0;
    assign ex_pc          = r_pc;
    assign ex_badv        = r_badv;
    assign redirect_pc    = r_redirect_pc;
    assign redirect_valid = (r_state == S_REDIRECT);
    assign busy           = (r_state != S_IDLE);
    assign flush          = busy;

endmodule
`default_nettype wire
